// File: rtl/trace_step_checker.sv
// trace_step_checker
// Walks a recorded execution trace through the combinational tiny86 step
// circuit. Each accepted step is presented on exec_step. The predicted
// register file for the following step (exec_regs) is captured and compared
// against the register block of the next accepted step. The verdict is
// either PASS or the first FAIL, reported with its step index and a
// per-register mismatch mask.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a new trace (honoured in IDLE/PASS/FAIL only)
//   step_valid/ready  step handshake; step_ready is a pure function of state
//   step_data         560-bit trace step, step_last marks the final step
//   exec_step         registered step driving tiny86
//   exec_regs         tiny86 prediction {eflags,eip,ebp,esp,edi,esi,edx,ecx,ebx,eax}
//   busy/done/pass    status
//   mismatch_mask     bit0=eax .. bit8=eip, bit9=eflags
//   fail_index        index of the first mismatching step
//   steps_checked     steps accepted since start (saturating)
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | step_ready high, waiting for a step
// CHECK | compare the accepted step against the previous prediction
// EXEC  | capture the tiny86 prediction for the next step
// PASS  | sticky verdict: trace consistent
// FAIL  | sticky verdict: mismatch latched
module trace_step_checker #(
    parameter int          CNT_W       = 32,
    parameter logic [31:0] EFLAGS_MASK = 32'h0000_08D5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_valid,
    input  logic [559:0]     step_data,
    input  logic             step_last,
    output logic             step_ready,
    output logic [559:0]     exec_step,
    input  logic [319:0]     exec_regs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [9:0]       mismatch_mask,
    output logic [CNT_W-1:0] fail_index,
    output logic [CNT_W-1:0] steps_checked
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CHECK, S_EXEC, S_PASS, S_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [559:0]       step_q, step_d;
    logic               last_q, last_d;
    logic [319:0]       exp_q, exp_d;
    logic               have_prev_q, have_prev_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [CNT_W-1:0]   fidx_q, fidx_d;
    logic [9:0]         mask_q, mask_d;
    logic [9:0]         cmp_mask;

    // GPRs and eip must match exactly; only the arithmetic flags are
    // meaningful in eflags, the rest are ignored.
    always_comb begin
        cmp_mask = '0;
        for (int r = 0; r < 9; r++) begin
            cmp_mask[r] = |(step_q[96 + 32*r +: 32] ^ exp_q[32*r +: 32]);
        end
        cmp_mask[9] = |((step_q[415:384] ^ exp_q[319:288]) & EFLAGS_MASK);
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        last_d      = last_q;
        exp_d       = exp_q;
        have_prev_d = have_prev_q;
        steps_d     = steps_q;
        fidx_d      = fidx_q;
        mask_d      = mask_q;
        case (state_q)
            S_IDLE, S_PASS, S_FAIL: begin
                if (start) begin
                    state_d     = S_FETCH;
                    have_prev_d = 1'b0;
                    steps_d     = '0;
                    fidx_d      = '0;
                    mask_d      = '0;
                end
            end
            S_FETCH: begin
                if (step_valid) begin
                    step_d  = step_data;
                    last_d  = step_last;
                    if (steps_q != '1) begin
                        steps_d = steps_q + CNT_W'(1);
                    end
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (have_prev_q && (cmp_mask != '0)) begin
                    state_d = S_FAIL;
                    mask_d  = cmp_mask;
                    fidx_d  = steps_q - CNT_W'(1);
                end else if (last_q) begin
                    state_d = S_PASS;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exp_d       = exec_regs;
                have_prev_d = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            last_q      <= 1'b0;
            exp_q       <= '0;
            have_prev_q <= 1'b0;
            steps_q     <= '0;
            fidx_q      <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            last_q      <= last_d;
            exp_q       <= exp_d;
            have_prev_q <= have_prev_d;
            steps_q     <= steps_d;
            fidx_q      <= fidx_d;
            mask_q      <= mask_d;
        end
    end

    assign step_ready    = (state_q == S_FETCH);
    assign busy          = (state_q == S_FETCH) || (state_q == S_CHECK) || (state_q == S_EXEC);
    assign done          = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass          = (state_q == S_PASS);
    assign exec_step     = step_q;
    assign mismatch_mask = mask_q;
    assign fail_index    = fidx_q;
    assign steps_checked = steps_q;

endmodule
